uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter GAP_CLKS, default 20: idle clocks inserted after each frame; 0 legal (no gap).
REQ-003 Parameter TIMEOUT_CLKS, default 4096: maximum clocks spent waiting for frame completion.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  bit i = requester i holds a byte to send.
REQ-007 req_data  input  NUM_REQ*8  byte for requester i at bits [8i+7:8i].
REQ-008 req_ready  output  NUM_REQ  one-hot, one-cycle pulse = byte of requester i accepted.
REQ-009 o_Tx_DV  output  1  one-cycle launch strobe to uart_tx i_Tx_DV.
REQ-010 o_Tx_Byte  output  8  byte to uart_tx i_Tx_Byte.
REQ-011 i_Tx_Active  input  1  from uart_tx o_Tx_Active.
REQ-012 i_Tx_Done  input  1  from uart_tx o_Tx_Done, one-cycle pulse at frame end.
REQ-013 grant_id  output  max(1,ceil(log2 NUM_REQ))  index of requester currently or last granted.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 timeout_err  output  1  sticky; set on a completion timeout.

Function
REQ-016 States: IDLE, LAUNCH, WAIT_DONE, GAP; encoding at implementer's discretion.
REQ-017 IDLE, at an edge with any req_valid high and i_Tx_Active low: select winner w, register grant_id<=w, o_Tx_Byte<=req_data[w], o_Tx_DV<=1, req_ready[w]<=1, go to LAUNCH.
REQ-018 IDLE with i_Tx_Active high: no launch; hold in IDLE regardless of req_valid.
REQ-019 Round-robin: search starts at (last_grant+1) mod NUM_REQ and ascends with wrap; first valid index wins.
REQ-020 last_grant updates to grant_id on leaving WAIT_DONE (done or timeout).
REQ-021 Latency: req_valid sampled high in IDLE at edge t -> o_Tx_DV and req_ready[w] high during cycle t+1 only.
REQ-022 LAUNCH lasts exactly one cycle, then WAIT_DONE; o_Tx_DV and req_ready return to 0.
REQ-023 o_Tx_Byte and grant_id are held stable from LAUNCH until the next launch.
REQ-024 Requester holds req_valid/req_data until it sees req_ready; deassertion at any other time has no effect on a frame in progress.
REQ-025 WAIT_DONE: 13-bit-or-wider timer counts from 0; i_Tx_Done high -> GAP (or IDLE if GAP_CLKS=0), timer cleared.
REQ-026 Timer reaching TIMEOUT_CLKS-1 with no i_Tx_Done -> timeout_err<=1, go to GAP/IDLE as in REQ-025.
REQ-027 i_Tx_Done in IDLE, LAUNCH or GAP is ignored.
REQ-028 GAP: counts GAP_CLKS cycles, then IDLE; req_valid ignored during GAP.
REQ-029 timeout_err clears only on reset.
REQ-030 Single requester continuously valid: served back-to-back, separated by frame time plus GAP_CLKS plus 1 IDLE cycle.

Reset
REQ-031 reset high at an edge: state<=IDLE, o_Tx_DV<=0, req_ready<=0, o_Tx_Byte<=8'h00, grant_id<=0, last_grant<=NUM_REQ-1, timers<=0, timeout_err<=0, busy=0.
REQ-032 Reset takes priority over every other event, including a launch or i_Tx_Done in the same cycle.
REQ-033 Reset mid-frame does not abort uart_tx; first post-reset launch waits for i_Tx_Active low (REQ-018).

Verification
REQ-034 After reset, req_valid=4'b0001, req_data[7:0]=8'hA5 -> one-cycle o_Tx_DV and req_ready=4'b0001 the next cycle, o_Tx_Byte=8'hA5, received o_Rx_Byte=8'hA5.
REQ-035 req_valid=4'b1111 held (ready-driven reload) -> grant order 0,1,2,3,0; each launch exactly GAP_CLKS+1 cycles after the previous i_Tx_Done.
REQ-036 last_grant=2, req_valid=4'b0011 -> requester 0 granted next (wrap-around), then 1.
REQ-037 i_Tx_Done tied low, TIMEOUT_CLKS=64 -> timeout_err rises 64 cycles after LAUNCH, arbiter returns to IDLE and serves next requester.
REQ-038 reset asserted during WAIT_DONE with i_Tx_Active high -> all outputs at reset values next cycle; no o_Tx_DV until i_Tx_Active falls.
REQ-039 GAP_CLKS=0, req_valid=4'b0010 held -> consecutive launches exactly 1 IDLE cycle after each i_Tx_Done.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int GAP_CLKS     = 20,
   parameter int TIMEOUT_CLKS = 4096
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*8-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       o_Tx_DV,
   output logic [7:0]                 o_Tx_Byte,
   input  logic                       i_Tx_Active,
   input  logic                       i_Tx_Done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       timeout_err
);
   localparam int GW = $clog2(NUM_REQ);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLKS - 1);
   localparam logic [31:0] GAP_LAST = 32'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;
   state_t state, state_n;
   logic [GW-1:0] last_grant, last_n, win, grant_n;
   logic [31:0] timer, timer_n;
   logic [NUM_REQ-1:0] ready_n;
   logic [7:0] byte_n;
   logic dv_n, err_n;
   // scan downward so the smallest offset past last_grant with a valid request is kept
   always_comb begin
      win = last_grant;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req_valid[(int'(last_grant) + k) % NUM_REQ]) win = GW'((int'(last_grant) + k) % NUM_REQ);
      end
   end
   // next state plus next values of every registered output
   always_comb begin
      state_n = state;
      dv_n = 1'b0;
      ready_n = '0;
      byte_n = o_Tx_Byte;
      grant_n = grant_id;
      last_n = last_grant;
      timer_n = timer;
      err_n = timeout_err;
      case (state)
         IDLE: begin
            if (|req_valid && !i_Tx_Active) begin
               state_n = LAUNCH;
               dv_n = 1'b1;
               ready_n = NUM_REQ'(1) << win;
               byte_n = req_data[8*win +: 8];
               grant_n = win;
            end
         end
         LAUNCH: begin
            state_n = WAIT_DONE;
            timer_n = '0;
         end
         WAIT_DONE: begin
            if (i_Tx_Done || timer == TO_LAST) begin
               state_n = (GAP_CLKS == 0) ? IDLE : GAP;
               timer_n = '0;
               last_n = grant_id;
               err_n = timeout_err | ~i_Tx_Done;
            end else begin
               timer_n = timer + 32'd1;
            end
         end
         GAP: begin
            state_n = (timer == GAP_LAST) ? IDLE : GAP;
            timer_n = (timer == GAP_LAST) ? '0 : timer + 32'd1;
         end
         default: state_n = IDLE;
      endcase
   end
   // state and output registers; reset overrides any launch or completion in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         o_Tx_DV <= 1'b0;
         req_ready <= '0;
         o_Tx_Byte <= 8'h00;
         grant_id <= '0;
         last_grant <= GW'(NUM_REQ - 1);
         timer <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_n;
         o_Tx_DV <= dv_n;
         req_ready <= ready_n;
         o_Tx_Byte <= byte_n;
         grant_id <= grant_n;
         last_grant <= last_n;
         timer <= timer_n;
         timeout_err <= err_n;
      end
   end
   assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random requesters and a uart_tx stand-in, checked against a timeline model
module tb_uart_tx_arbiter;
   localparam int NUM = 4;
   localparam int G = 3;
   localparam int TO = 64;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0] req_ready;
   logic o_Tx_DV;
   logic [7:0] o_Tx_Byte;
   logic i_Tx_Active = 1'b0;
   logic i_Tx_Done = 1'b0;
   logic [1:0] grant_id;
   logic busy, timeout_err;
   int n_cmp = 0, n_bad = 0, cyc = 0, free_at = 0, launch_at = 0, err_at = 0, last = NUM - 1, rem = 0, mode = 0;
   bit model_ok = 1'b0, inflight = 1'b0, drop_en = 1'b0, force_drop = 1'b0, e_dv = 1'b0, eb;
   logic [3:0] e_rdy = '0, rdy_q = '0;
   logic [7:0] e_byte = '0;
   logic [1:0] e_gid = '0;
   int gq[$];
   int bq[$];
   int ord[5] = '{0, 1, 2, 3, 0};

   uart_tx_arbiter #(.NUM_REQ(NUM), .GAP_CLKS(G), .TIMEOUT_CLKS(TO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic int rr(logic [3:0] v, int l);
      for (int k = 1; k <= NUM; k++) if (v[(l + k) % NUM]) return (l + k) % NUM;
      return 0;
   endfunction

   // reference timeline: a launch follows one cycle after an idle cycle with a request and a quiet uart;
   // the frame ends on done or after TO waiting cycles, then G gap cycles precede the next idle cycle
   always @(negedge clk) begin
      int w;
      cyc++;
      rdy_q = req_ready;
      if (model_ok) begin
         eb = inflight || cyc < free_at;
         check("dv", 32'(o_Tx_DV), 32'(e_dv));
         check("ready", 32'(req_ready), 32'(e_rdy));
         check("byte", 32'(o_Tx_Byte), 32'(e_byte));
         check("grant", 32'(grant_id), 32'(e_gid));
         check("busy", 32'(busy), 32'(eb));
         check("err", 32'(timeout_err), 32'(cyc >= err_at));
         if (o_Tx_DV) begin
            gq.push_back(int'(grant_id));
            bq.push_back(int'(o_Tx_Byte));
         end
      end
      if (reset) begin
         model_ok = 1'b1;
         inflight = 1'b0;
         free_at = cyc + 1;
         last = NUM - 1;
         e_dv = 1'b0;
         e_rdy = '0;
         e_byte = '0;
         e_gid = '0;
         err_at = 1 << 30;
      end else begin
         if (inflight && cyc > launch_at && (i_Tx_Done || cyc == launch_at + TO)) begin
            if (!i_Tx_Done && err_at > cyc + 1) err_at = cyc + 1;
            last = int'(e_gid);
            inflight = 1'b0;
            free_at = cyc + 1 + G;
         end
         e_dv = 1'b0;
         e_rdy = '0;
         if (!inflight && cyc >= free_at && |req_valid && !i_Tx_Active) begin
            w = rr(req_valid, last);
            e_dv = 1'b1;
            e_rdy = 4'(1 << w);
            e_byte = req_data[8*w +: 8];
            e_gid = 2'(w);
            inflight = 1'b1;
            launch_at = cyc + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      i_Tx_Done = 1'b0;
      if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            i_Tx_Active = 1'b0;
            i_Tx_Done = 1'b1;
         end
      end
      if (o_Tx_DV && !(force_drop || (drop_en && $urandom_range(0, 7) == 0))) begin
         i_Tx_Active = 1'b1;
         rem = $urandom_range(4, 20);
      end
      for (int i = 0; i < NUM; i++) begin
         if (rdy_q[i]) begin
            req_valid[i] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_data[8*i +: 8] = 8'($urandom);
         end else if (mode == 2 && !req_valid[i] && $urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
         end
      end
   endtask

   initial begin
      repeat (3) step();
      reset = 1'b0;
      req_valid = 4'b0001;
      req_data[7:0] = 8'hA5;
      repeat (40) step();
      check("a5_count", 32'(bq.size()), 32'd1);
      if (bq.size() > 0) check("a5_byte", 32'(bq[0]), 32'hA5);
      if (gq.size() > 0) check("a5_grant", 32'(gq[0]), 32'd0);
      reset = 1'b1;
      mode = 1;
      req_valid = 4'b1111;
      req_data = $urandom;
      step();
      reset = 1'b0;
      gq.delete();
      bq.delete();
      for (int k = 0; k < 500 && gq.size() < 5; k++) step();
      check("order_count", 32'(gq.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < gq.size(); k++) check("order", 32'(gq[k]), 32'(ord[k]));
      mode = 2;
      drop_en = 1'b1;
      repeat (2500) step();
      force_drop = 1'b1;
      repeat (300) step();
      force_drop = 1'b0;
      drop_en = 1'b0;
      check("err_sticky", 32'(timeout_err), 32'd1);
      for (int k = 0; k < 300 && !(i_Tx_Active && busy); k++) step();
      check("frame_seen", 32'(i_Tx_Active && busy), 32'd1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_dv", 32'(o_Tx_DV), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(timeout_err), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_byte", 32'(o_Tx_Byte), 32'd0);
      repeat (300) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
